touch_score_ctrl: RTL and testbench

//  Rally referee between the collision detectors and ball_pos_ctrl. Counts touches per side, flags a
//  4th consecutive touch as a fault (ovr_touch), and awards the point on a fault or a ground hit.

---
 rtl/touch_score_if.sv | 26 ++
 rtl/touch_score_ctrl.sv | 164 ++++++++++++++++
 tb/tb_touch_score_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/touch_score_if.sv
// Signal bundle between the rally referee and the collision detectors / ball
// controller.
interface touch_score_if;
    logic        pl1_col;
    logic        pl2_col;
    logic        gnd_col;
    logic [11:0] ball_posx;
    logic        restart;
    logic        ovr_touch;
    logic        last_touch;
    logic [3:0]  pl1_score;
    logic [3:0]  pl2_score;
    logic        point_pls;
    logic        game_over;
    logic        winner;

    modport master (
        output pl1_col, pl2_col, gnd_col, ball_posx, restart,
        input  ovr_touch, last_touch, pl1_score, pl2_score, point_pls, game_over, winner
    );

    modport slave (
        input  pl1_col, pl2_col, gnd_col, ball_posx, restart,
        output ovr_touch, last_touch, pl1_score, pl2_score, point_pls, game_over, winner
    );
endinterface

// File: rtl/touch_score_ctrl.sv
// Rally referee: counts touches per side, flags over-touch faults, awards points
// on faults and ground hits, keeps score and detects game over.
module touch_score_ctrl #(
    parameter int MAX_TOUCH    = 3,
    parameter int GHOST_CYCLES = 3_250_000,
    parameter int BLANK_CYCLES = 1_000_000,
    parameter int NET_X        = 512,
    parameter int BALL_HALF    = 32,
    parameter int WIN_SCORE    = 15,
    parameter int CNT_W        = 24
) (
    input  logic         clk,
    input  logic         rst,
    touch_score_if.slave ts
);

    localparam int               TC_W      = $clog2(MAX_TOUCH + 1);
    localparam logic [CNT_W-1:0] GHOST_MAX = CNT_W'(GHOST_CYCLES);
    localparam logic [CNT_W-1:0] BLANK_MAX = CNT_W'(BLANK_CYCLES);
    localparam logic [12:0]      NET_X13   = 13'(NET_X);
    localparam logic [12:0]      HALF13    = 13'(BALL_HALF);
    localparam logic [3:0]       WIN4      = 4'(WIN_SCORE);

    typedef enum logic [1:0] {S_SERVE, S_RALLY, S_POINT, S_OVER} state_t;

    state_t            state, state_nx;
    logic              pl1_col_q, pl2_col_q, gnd_col_q;
    logic [CNT_W-1:0]  ghost_cnt, blank_cnt;
    logic [TC_W-1:0]   touch_cnt;
    logic              toucher;
    logic [3:0]        pl1_score_q, pl2_score_q;
    logic              last_touch_q, winner_q, ovr_q, point_q;
    logic              game_over, in_play;

    logic              pl1_rise, pl2_rise, gnd_evt, ghost_done, blank_done;
    logic              touch_acc, touch_pl, same_poss, fault, award, award_to, win_hit;
    logic [12:0]       ball_centre;
    logic [3:0]        new_score;

    assign pl1_rise    = ts.pl1_col & ~pl1_col_q;
    assign pl2_rise    = ts.pl2_col & ~pl2_col_q;
    assign gnd_evt     = ts.gnd_col & ~gnd_col_q & (state == S_RALLY);
    assign ghost_done  = (ghost_cnt >= GHOST_MAX);
    assign blank_done  = (blank_cnt >= BLANK_MAX);
    assign ball_centre = {1'b0, ts.ball_posx} + HALF13;

    // Touch arbitration: a ground edge wins over touches, P1 wins over P2. The
    // ghost window only filters repeat edges within a rally; a serve always counts.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        touch_acc = 1'b0;
        touch_pl  = 1'b0;
        if (in_play && !gnd_evt) begin
            if (pl1_rise) begin
                touch_pl  = 1'b0;
                touch_acc = (state == S_SERVE) || toucher || ghost_done;
            end else if (pl2_rise) begin
                touch_pl  = 1'b1;
                touch_acc = (state == S_SERVE) || !toucher || ghost_done;
            end
        end
    end

    assign same_poss = (state == S_RALLY) && (touch_pl == toucher);
    assign fault     = touch_acc && same_poss && (touch_cnt == TC_W'(MAX_TOUCH));
    assign award     = fault || gnd_evt;
    assign award_to  = fault ? ~touch_pl : (ball_centre < NET_X13);
    assign new_score = award_to ? pl2_score_q + 4'd1 : pl1_score_q + 4'd1;
    assign win_hit   = (new_score == WIN4);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_SERVE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_SERVE: if (touch_acc) state_nx = S_RALLY;
            S_RALLY: if (award) state_nx = win_hit ? S_OVER : S_POINT;
            S_POINT: if (blank_done && !ts.gnd_col) state_nx = S_SERVE;
            S_OVER:  if (ts.restart) state_nx = S_SERVE;
            default: state_nx = S_SERVE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        game_over = (state == S_OVER);
        in_play   = (state == S_SERVE) || (state == S_RALLY);
    end

    // Datapath: edge registers, counters, scores and pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pl1_col_q    <= 1'b0;
            pl2_col_q    <= 1'b0;
            gnd_col_q    <= 1'b0;
            ghost_cnt    <= '0;
            blank_cnt    <= '0;
            touch_cnt    <= '0;
            toucher      <= 1'b0;
            pl1_score_q  <= '0;
            pl2_score_q  <= '0;
            last_touch_q <= 1'b0;
            winner_q     <= 1'b0;
            ovr_q        <= 1'b0;
            point_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            pl1_col_q <= ts.pl1_col;
            pl2_col_q <= ts.pl2_col;
            gnd_col_q <= ts.gnd_col;
            ovr_q     <= 1'b0;
            point_q   <= 1'b0;

            if (touch_acc)        ghost_cnt <= '0;
            else if (!ghost_done) ghost_cnt <= ghost_cnt + 1'b1;

            if (touch_acc && !fault) begin
                if (!same_poss) begin
                    toucher   <= touch_pl;
                    touch_cnt <= TC_W'(1);
                end else begin
                    touch_cnt <= touch_cnt + 1'b1;
                end
            end

            if (award) begin
                if (award_to) begin
                    if (pl2_score_q != WIN4) pl2_score_q <= new_score;
                end else begin
                    if (pl1_score_q != WIN4) pl1_score_q <= new_score;
                end
                last_touch_q <= award_to;
                point_q      <= 1'b1;
                ovr_q        <= fault;
                touch_cnt    <= '0;
                blank_cnt    <= '0;
                if (win_hit) winner_q <= award_to;
            end

            if (state == S_POINT && !blank_done) blank_cnt <= blank_cnt + 1'b1;

            if (state == S_OVER && ts.restart) begin
                pl1_score_q  <= '0;
                pl2_score_q  <= '0;
                last_touch_q <= 1'b0;
                touch_cnt    <= '0;
            end
        end
    end

    assign ts.ovr_touch  = ovr_q;
    assign ts.point_pls  = point_q;
    assign ts.last_touch = last_touch_q;
    assign ts.pl1_score  = pl1_score_q;
    assign ts.pl2_score  = pl2_score_q;
    assign ts.winner     = winner_q;
    assign ts.game_over  = game_over;

endmodule

// File: tb/tb_touch_score_ctrl.sv
// Scoreboard bench for touch_score_ctrl: an event-level referee model predicts
// every point award; a monitor compares each point_pls against the queue.
module tb_touch_score_ctrl;
    localparam int GHOST = 8;
    localparam int BLANK = 16;
    localparam int WIN   = 3;
    localparam int MAXT  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    touch_score_if ts();

    touch_score_ctrl #(
        .MAX_TOUCH(MAXT), .GHOST_CYCLES(GHOST), .BLANK_CYCLES(BLANK),
        .NET_X(512), .BALL_HALF(32), .WIN_SCORE(WIN), .CNT_W(24)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ts (ts)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected point award: {ovr, pl1, pl2, last, game_over}
    typedef struct {
        int          cyc;
        logic [10:0] vec;
        logic        go;
        logic        win;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- Reference model (event level) ----------------
    typedef enum {M_SERVE, M_RALLY, M_POINT, M_OVER} mode_t;
    mode_t m_mode;
    int    m_toucher, m_cnt, m_last_cyc, m_award_cyc, m_gnd_fall;
    int    m_s[2];
    int    m_serve;

    function automatic void model_reset();
        m_mode     = M_SERVE;
        m_toucher  = 0;
        m_cnt      = 0;
        m_last_cyc = -1000;
        m_award_cyc = -1000;
        m_gnd_fall = -1000;
        m_s[0]     = 0;
        m_s[1]     = 0;
        m_serve    = 0;
    endfunction

    // Play resumes once the blank time has elapsed and the ball is off the ground.
    function automatic void model_sync(input int c);
        if (m_mode == M_POINT && (c - m_award_cyc) >= BLANK + 2 && !ts.gnd_col && (c - m_gnd_fall) >= 2)
            m_mode = M_SERVE;
    endfunction

    function automatic void award(input int w, input bit ovr, input int c);
        exp_t e;
        m_s[w]++;
        m_serve = w;
        m_cnt   = 0;
        e.cyc = c + 1;
        e.go  = (m_s[w] == WIN);
        e.win = w[0];
        e.vec = {ovr, 4'(m_s[0]), 4'(m_s[1]), w[0], e.go};
        exp_q.push_back(e);
        m_mode      = e.go ? M_OVER : M_POINT;
        m_award_cyc = c;
    endfunction

    function automatic void touch_ev(input int p, input int c);
        model_sync(c);
        if (m_mode != M_SERVE && m_mode != M_RALLY) return;
        if (m_mode == M_RALLY && p == m_toucher && (c - m_last_cyc) <= GHOST) return;
        m_last_cyc = c;
        if (m_mode == M_SERVE || p != m_toucher) begin
            m_toucher = p;
            m_cnt     = 1;
            m_mode    = M_RALLY;
        end else if (m_cnt == MAXT) begin
            award(1 - p, 1'b1, c);
        end else begin
            m_cnt++;
        end
    endfunction

    function automatic bit gnd_ev(input int posx, input int c);
        model_sync(c);
        if (m_mode != M_RALLY) return 1'b0;
        award((posx + 32 < 512) ? 1 : 0, 1'b0, c);
        return 1'b1;
    endfunction

    // ---------------- Stimulus helpers ----------------
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_col(input int p, input logic v);
        if (p == 0) ts.pl1_col = v;
        else        ts.pl2_col = v;
    endtask

    task automatic touch(input int p, input int gap);
        set_col(p, 1'b1);
        touch_ev(p, cyc);
        tick(1);
        set_col(p, 1'b0);
        tick(gap - 1);
    endtask

    task automatic both_touch(input int gap);
        ts.pl1_col = 1'b1;
        ts.pl2_col = 1'b1;
        touch_ev(0, cyc);
        tick(1);
        ts.pl1_col = 1'b0;
        ts.pl2_col = 1'b0;
        tick(gap - 1);
    endtask

    task automatic gnd(input int posx, input int hold);
        bit used;
        ts.ball_posx = 12'(posx);
        ts.gnd_col   = 1'b1;
        used = gnd_ev(posx, cyc);
        tick(hold);
        ts.gnd_col = 1'b0;
        m_gnd_fall = cyc;
        tick(1);
    endtask

    task automatic do_restart();
        ts.restart = 1'b1;
        model_sync(cyc);
        if (m_mode == M_OVER) begin
            m_s[0]  = 0;
            m_s[1]  = 0;
            m_serve = 0;
            m_mode  = M_SERVE;
        end
        tick(1);
        ts.restart = 1'b0;
        tick(1);
    endtask

    task automatic wait_serve();
        tick(BLANK + 12);
    endtask

    task automatic check_scores(input string tag);
        check({tag, "_pl1"}, 32'(ts.pl1_score), 32'(m_s[0]));
        check({tag, "_pl2"}, 32'(ts.pl2_score), 32'(m_s[1]));
        check({tag, "_last"}, 32'(ts.last_touch), 32'(m_serve));
        check({tag, "_over"}, 32'(ts.game_over), 32'(m_mode == M_OVER));
    endtask

    // ---------------- Monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (ts.point_pls) begin
                if (exp_q.size() == 0) begin
                    check("spurious_point", 32'(ts.point_pls), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("point_cycle", 32'(cyc), 32'(e.cyc));
                    check("point_fields", 32'({ts.ovr_touch, ts.pl1_score, ts.pl2_score,
                                               ts.last_touch, ts.game_over}), 32'(e.vec));
                    if (e.go) check("winner", 32'(ts.winner), 32'(e.win));
                end
            end else if (ts.ovr_touch) begin
                check("lone_ovr_touch", 32'(ts.ovr_touch), 32'd0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- Test sequence ----------------
    initial begin
        bit used;
        ts.pl1_col = 1'b0; ts.pl2_col = 1'b0; ts.gnd_col = 1'b0;
        ts.ball_posx = '0; ts.restart = 1'b0;
        model_reset();
        rst = 1'b1;
        tick(3);
        #2 rst = 1'b0;
        tick(2);
        check("rst_ovr", 32'(ts.ovr_touch), 32'd0);
        check("rst_pulse", 32'(ts.point_pls), 32'd0);
        check("rst_winner", 32'(ts.winner), 32'd0);
        check_scores("rst");

        // Long contact is one touch; a bounce inside the ghost window is dropped;
        // the fourth real P1 touch is a fault.
        ts.pl1_col = 1'b1;
        touch_ev(0, cyc);
        tick(20);
        ts.pl1_col = 1'b0;
        tick(10);
        touch(0, 4);
        touch(0, 10);
        touch(0, 10);
        touch(0, 10);
        wait_serve();
        check_scores("t1");

        // P1,P1,P2,P2,P2 is legal; a fourth P2 touch faults.
        touch(0, 10); touch(0, 10);
        touch(1, 10); touch(1, 10); touch(1, 10);
        touch(1, 10);
        wait_serve();
        check_scores("t2");

        // Asynchronous reset between clock edges mid-rally.
        touch(0, 10);
        touch(1, 5);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_pl1", 32'(ts.pl1_score), 32'd0);
        check("arst_pl2", 32'(ts.pl2_score), 32'd0);
        check("arst_last", 32'(ts.last_touch), 32'd0);
        check("arst_pulses", 32'({ts.ovr_touch, ts.point_pls, ts.game_over}), 32'd0);
        model_reset();
        tick(2);
        #2 rst = 1'b0;
        tick(2);

        // Ground side decision around the net.
        touch(1, 10);
        gnd(400, 1);
        wait_serve();
        touch(0, 10);
        gnd(480, 1);
        wait_serve();
        check_scores("t3");

        // Simultaneous player edges: P1 only.
        both_touch(10);
        touch(0, 10); touch(0, 10); touch(0, 10);
        wait_serve();

        // Ground coincides with what would be a fault; ground held through POINT.
        touch(1, 10); touch(1, 10); touch(1, 10);
        ts.ball_posx = 12'd600;
        ts.gnd_col = 1'b1;
        ts.pl2_col = 1'b1;
        used = gnd_ev(600, cyc);
        if (!used) touch_ev(1, cyc);
        tick(1);
        ts.pl2_col = 1'b0;
        tick(29);
        touch(1, 10); touch(1, 10); touch(1, 10); touch(1, 10);
        ts.gnd_col = 1'b0;
        m_gnd_fall = cyc;
        tick(10);
        check_scores("t4");

        // P1 reaches WIN_SCORE; everything but restart is ignored.
        touch(1, 10);
        gnd(700, 1);
        tick(5);
        check("go_winner", 32'(ts.winner), 32'd0);
        touch(1, 10); touch(1, 10); touch(1, 10); touch(1, 10);
        gnd(100, 1);
        wait_serve();
        check_scores("t5_over");
        do_restart();
        check_scores("t5_restart");

        // restart is ignored outside GAME_OVER.
        touch(0, 10);
        do_restart();
        gnd(100, 1);
        wait_serve();
        check_scores("t5_norestart");

        // Randomised rallies.
        for (int r = 0; r < 30; r++) begin
            int n;
            touch(int'($urandom_range(0, 1)), int'($urandom_range(11, 16)));
            n = int'($urandom_range(0, 6));
            for (int k = 0; k < n; k++) begin
                int gap;
                gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(3, 6))
                                                   : int'($urandom_range(11, 16));
                touch(int'($urandom_range(0, 1)), gap);
                if (m_mode != M_RALLY) break;
            end
            if (m_mode == M_RALLY) gnd(int'($urandom_range(0, 959)), int'($urandom_range(1, 3)));
            wait_serve();
            check_scores("rnd");
            if (m_mode == M_OVER) do_restart();
        end

        tick(40);
        check("pending_points", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
